// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: branch type codes and the
// 2-bit saturating counter encodings used by the prediction table.
package branch_ctrl_pkg;

   localparam logic [1:0] NONE_BR = 2'b00;
   localparam logic [1:0] BEQ     = 2'b01;
   localparam logic [1:0] BLT     = 2'b10;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2^IDX_W two-bit saturating counters.
// One combinational read port and one saturating-update write port.
// A read that hits the entry being written returns the pre-update value.
module bht_table
   import branch_ctrl_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_ctr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   ctr_e ctr_q [2**IDX_W];

   // Move one step toward taken or not-taken, holding at either end.
   function automatic ctr_e sat_step(input ctr_e c, input logic taken);
      ctr_e n;
      n = c;
      case (c)
         SNT:     n = taken ? WNT : SNT;
         WNT:     n = taken ? WT  : SNT;
         WT:      n = taken ? ST  : WNT;
         ST:      n = taken ? ST  : WT;
         default: n = WNT;
      endcase
      return n;
   endfunction

   // Counter array: all entries start weakly not-taken, trained on resolution.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**IDX_W; i++) ctr_q[i] <= WNT;
      end else if (wr_en) begin
         ctr_q[wr_idx] <= sat_step(ctr_q[wr_idx], wr_taken);
      end
   end

   assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch prediction and control-flow recovery controller.
// gshare prediction in ID, mispredict detection/recovery and training in EX.
// Optional macro BRANCH_STAT_EN adds resolved-branch and mispredict counters;
// without it br_total/br_miss are tied to 0.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int BHT_IDX_W = 6,
   parameter int PC_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [PC_W-1:0]      id_pc,
   input  logic [1:0]           id_br_type,
   input  logic [PC_W-1:0]      id_target,
   output logic                 id_pred_taken,
   output logic [BHT_IDX_W-1:0] id_bht_idx,
   input  logic [1:0]           ex_br_type,
   input  logic                 ex_br,
   input  logic                 ex_pred_taken,
   input  logic [BHT_IDX_W-1:0] ex_bht_idx,
   input  logic [PC_W-1:0]      ex_target,
   input  logic [PC_W-1:0]      ex_pc,
   output logic                 pc_redirect,
   output logic [PC_W-1:0]      redirect_pc,
   output logic                 flush_ifid,
   output logic                 flush_idex,
   output logic [31:0]          br_total,
   output logic [31:0]          br_miss
);

   logic [BHT_IDX_W-1:0] ghr_q;
   logic [BHT_IDX_W-1:0] idx;
   logic [1:0]           rd_ctr;
   logic                 pred;
   logic                 ex_res;
   logic                 mis;

   assign idx    = id_pc[BHT_IDX_W+1:2] ^ ghr_q;
   assign pred   = (id_br_type != NONE_BR) & rd_ctr[1];
   // A stalled EX slot is held, so it resolves only once, on release.
   assign ex_res = (ex_br_type != NONE_BR) & ~stall;
   assign mis    = ex_res & (ex_br != ex_pred_taken);

   bht_table #(
      .IDX_W (BHT_IDX_W)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx),
      .rd_ctr   (rd_ctr),
      .wr_en    (ex_res),
      .wr_idx   (ex_bht_idx),
      .wr_taken (ex_br)
   );

   // Global history shifts in resolved outcomes only (non-speculative).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
      end else if (ex_res) begin
         ghr_q <= {ghr_q[BHT_IDX_W-2:0], ex_br};
      end
   end

   // Prediction outputs and redirect selection; EX recovery beats ID redirect.
   always_comb begin
      id_bht_idx    = '0;
      id_pred_taken = 1'b0;
      pc_redirect   = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      redirect_pc   = '0;
      if (!rst) begin
         id_bht_idx    = idx;
         id_pred_taken = pred;
         if (mis) begin
            pc_redirect = 1'b1;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            redirect_pc = ex_br ? ex_target : ex_pc + PC_W'(4);
         end else if (pred && !stall) begin
            pc_redirect = 1'b1;
            flush_ifid  = 1'b1;
            redirect_pc = id_target;
         end
      end
   end

`ifdef BRANCH_STAT_EN
   logic [31:0] total_q;
   logic [31:0] miss_q;

   // Wrapping counts of resolved branches and mispredicts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         total_q <= '0;
         miss_q  <= '0;
      end else begin
         if (ex_res) total_q <= total_q + 32'd1;
         if (mis)    miss_q  <= miss_q + 32'd1;
      end
   end

   assign br_total = total_q;
   assign br_miss  = miss_q;
`else
   assign br_total = '0;
   assign br_miss  = '0;
`endif

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch prediction and control-flow recovery controller for the 5-stage pipeline.
- In ID, it predicts conditional branches (BEQ/BLT) with a gshare table of 2-bit saturating counters and redirects fetch on a predicted-taken branch.
- In EX, it takes the branch comparator's `br` outcome, detects mispredicts, flushes the wrong-path stages, redirects PC and trains the table.

Parameters:
- BHT_IDX_W, 6, log2 of table entries (64 counters); also the global history register width.
- PC_W, 32, PC width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  pipeline stall; EX/ID contents held this cycle
- id_pc  in  PC_W  PC of the instruction in ID
- id_br_type  in  2  branch type decoded in ID (00 none, 01 BEQ, 10 BLT)
- id_target  in  PC_W  branch target computed in ID
- id_pred_taken  out  1  prediction for the ID branch; travels down the pipe
- id_bht_idx  out  BHT_IDX_W  table index used for the prediction; travels down the pipe
- ex_br_type  in  2  branch type of the instruction in EX
- ex_br  in  1  comparator outcome (1 = taken)
- ex_pred_taken  in  1  piped id_pred_taken
- ex_bht_idx  in  BHT_IDX_W  piped id_bht_idx
- ex_target  in  PC_W  branch target of the EX instruction
- ex_pc  in  PC_W  PC of the EX instruction
- pc_redirect  out  1  select redirect_pc as next fetch PC
- redirect_pc  out  PC_W  next PC on redirect
- flush_ifid  out  1  squash the IF/ID register
- flush_idex  out  1  squash the ID/EX register
- br_total  out  32  resolved-branch count (BRANCH_STAT_EN)
- br_miss  out  32  mispredict count (BRANCH_STAT_EN)

Behaviour:
- Reset (async, rst=1):
  - All counters go to WNT (01) and GHR goes to 0.
  - Stat counters go to 0.
  - All outputs read 0 while rst is high; combinational outputs are gated by rst.
- Index: idx = id_pc[BHT_IDX_W+1:2] XOR GHR.
- Prediction (combinational, 0 latency):
  - id_bht_idx = idx.
  - id_pred_taken = (id_br_type != 00) & counter[idx][1].
- EX resolution event: ex_res = (ex_br_type != 00) & ~stall. Stalled cycles never resolve, so there is no double training.
- Mispredict: mis = ex_res & (ex_br != ex_pred_taken).
- Redirect priority, EX over ID:
  - If mis:
    - pc_redirect=1, flush_ifid=1, flush_idex=1.
    - redirect_pc = ex_br ? ex_target : ex_pc+4.
  - Else if id_pred_taken & ~stall:
    - pc_redirect=1, flush_ifid=1, flush_idex=0.
    - redirect_pc = id_target.
  - Otherwise all three are 0 and redirect_pc = 0.
- Training (posedge clk, when ex_res):
  - counter[ex_bht_idx] saturates up if ex_br=1, down if ex_br=0.
  - Encodings: 00 SNT, 01 WNT, 10 WT, 11 ST. 11+taken stays 11; 00+not-taken stays 00.
  - GHR <= {GHR[BHT_IDX_W-2:0], ex_br}. History is non-speculative and updated only at resolution.
- Read/write collision: if ID reads the index EX writes in the same cycle, ID sees the pre-update value and GHR is the pre-shift value.
- BLT compares unsigned. The controller does not re-evaluate it; ex_br is authoritative.
- Reset mid-operation: state clears immediately and redirect/flush drop to 0 in the same cycle.

Optional Feature:
- Macro: BRANCH_STAT_EN.
- Defined:
  - br_total increments on every ex_res.
  - br_miss increments on every mis.
  - Both are 32-bit wrapping counters, reset to 0.
- Undefined: both ports remain and are tied to 0; no counter flops are synthesized.

Decomposition:
- Shared package: branch type constants (NONE_BR=2'b00, BEQ=2'b01, BLT=2'b10) and counter encodings (SNT, WNT, WT, ST).
- One sub-module, bht_table:
  - Holds the 2^BHT_IDX_W x 2-bit array with async reset.
  - One combinational read port and one saturating-update write port.
- GHR, redirect priority and stat counters stay in branch_ctrl.

Test Plan:
- Reset then BEQ in ID at id_pc=0x40, GHR=0 -> id_bht_idx=0x10, id_pred_taken=0, no redirect. EX resolves with ex_br=1 -> pc_redirect=1, redirect_pc=ex_target, both flushes=1, counter[0x10]=10, GHR=000001.
- Train one index taken 4x -> counter stops at 11 (saturates). Then 1x not-taken -> counter 10, prediction still taken.
- ID predicts taken (id_target=0x100) while EX mispredicts not-taken (ex_pc=0x20) in the same cycle -> redirect_pc=0x24, flush_idex=1 (EX wins).
- ex_br_type=BLT with stall=1 for 3 cycles, then released -> exactly one counter update, one GHR shift and one br_total increment.
- Same-cycle read/write to index 0x05 with the counter at 01 and ex_br=1 -> id_pred_taken=0 this cycle; a re-read next cycle gives 1 (given an unchanged index).
- BRANCH_STAT_EN with 10 branches, 3 mispredicted -> br_total=10, br_miss=3. Asserting rst mid-run -> both 0 immediately.
